// File: rtl/rotary_shaft_decoder_pkg.sv
// Shared constants and quadrature helpers for the rotary shaft decoder.
// Latency: n/a (package only).
// Backpressure: n/a.
package rotary_shaft_decoder_pkg;

    // Default number of consecutive agreeing samples before a pin change is accepted.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

    // Debounce counter width; covers DEBOUNCE_CYCLES range 1..15.
    localparam int DBNC_CNT_W = 4;

    // Width of the signed detent tally.
    localparam int STEP_CNT_W = 8;

    typedef logic [DBNC_CNT_W-1:0] dbnc_cnt_t;
    typedef logic [STEP_CNT_W-1:0] step_cnt_t;

    // Filtered channel pair, A in bit 1 and B in bit 0.
    typedef enum logic [1:0] {
        QUAD_00 = 2'b00,
        QUAD_01 = 2'b01,
        QUAD_10 = 2'b10,
        QUAD_11 = 2'b11
    } quad_t;

    // Next signed tally value: left (counter-clockwise) detents count down.
    function automatic step_cnt_t step_next(input step_cnt_t cur, input logic left);
        step_next = left ? (cur - STEP_CNT_W'(1)) : (cur + STEP_CNT_W'(1));
    endfunction

endpackage

// File: rtl/rotary_shaft_decoder_rot_debounce.sv
// Two-flop synchronizer plus optional persistence filter for one quadrature pin.
// Latency: 2 cycles sync, plus DEBOUNCE_CYCLES when ROT_DEBOUNCE_EN is defined.
// Backpressure: none; free-running sampler.
// Ports: clk, reset (async active-high), pin (raw async input), filt (filtered level).
// Build option: ROT_DEBOUNCE_EN builds the filter; otherwise filt is the synchronized pin.
module rot_debounce
    import rotary_shaft_decoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic filt
);

    // Reject out-of-range settings at elaboration; the counter is only 4 bits wide.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce
        $error("rot_debounce: DEBOUNCE_CYCLES must be 1..15");
    end

    logic sync_1;
    logic sync_2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= pin;
            sync_2 <= sync_1;
        end
    end

`ifdef ROT_DEBOUNCE_EN
    localparam dbnc_cnt_t CNT_LAST = DBNC_CNT_W'(DEBOUNCE_CYCLES - 1);

    dbnc_cnt_t cnt;

    // cnt counts consecutive disagreeing samples; the sample that makes it
    // DEBOUNCE_CYCLES long is accepted. Any agreeing sample restarts the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (sync_2 == filt) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            filt <= sync_2;
        end else begin
            cnt <= cnt + DBNC_CNT_W'(1);
        end
    end
`else
    assign filt = sync_2;
`endif

endmodule

// File: rtl/rotary_shaft_decoder.sv
// Rotary encoder quadrature decoder: detent level, direction, strobe and signed tally.
// Latency: pin to rot_event 2+DEBOUNCE_CYCLES+1 cycles (3 without ROT_DEBOUNCE_EN).
// Backpressure: none; rot_pulse is a single-cycle strobe that is never held.
// Ports: clk, reset (async active-high), rota/rotb (raw async encoder channels),
//        rot_event (detent level), rot_left (1 = counter-clockwise),
//        rot_pulse (one cycle per detent), step_count (signed tally).
// Build option: ROT_DEBOUNCE_EN enables the per-channel persistence filters.
module rotary_shaft_decoder
    import rotary_shaft_decoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rota,
    input  logic                  rotb,
    output logic                  rot_event,
    output logic                  rot_left,
    output logic                  rot_pulse,
    output logic [STEP_CNT_W-1:0] step_count
);

    logic  filt_a;
    logic  filt_b;
    quad_t quad;
    logic  q1;
    logic  q2;
    logic  q1_d;
    logic  q1_rise;

    rot_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_dbnc_a (
        .clk   (clk),
        .reset (reset),
        .pin   (rota),
        .filt  (filt_a)
    );

    rot_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_dbnc_b (
        .clk   (clk),
        .reset (reset),
        .pin   (rotb),
        .filt  (filt_b)
    );

    assign quad    = quad_t'({filt_a, filt_b});
    assign q1_rise = q1 & ~q1_d;

    // q1 tracks the detent (00/11), q2 remembers which channel led (01/10).
    // A direct 00<->11 jump only moves q1, so rot_left then reports the last
    // q2 seen, which is the intended behaviour for a skipped intermediate state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q1         <= 1'b0;
            q2         <= 1'b0;
            q1_d       <= 1'b0;
            rot_left   <= 1'b0;
            rot_pulse  <= 1'b0;
            step_count <= '0;
        end else begin
            case (quad)
                QUAD_00: q1 <= 1'b0;
                QUAD_11: q1 <= 1'b1;
                QUAD_01: q2 <= 1'b0;
                QUAD_10: q2 <= 1'b1;
                default: ;
            endcase

            q1_d      <= q1;
            rot_pulse <= q1_rise;

            // q2 cannot change while q1 is rising (filtered pair is 11), so the
            // value sampled here is the one present when q1 went high.
            if (q1_rise) begin
                rot_left <= q2;
            end

            if (rot_pulse) begin
                step_count <= step_next(step_count, rot_left);
            end
        end
    end

    assign rot_event = q1;

endmodule

// File: tb/tb_rotary_shaft_decoder.sv
module tb_rotary_shaft_decoder;

    localparam int D = 4;
`ifdef ROT_DEBOUNCE_EN
    localparam int LAT  = 2 + D + 1;
    localparam bit DBNC = 1'b1;
`else
    localparam int LAT  = 3;
    localparam bit DBNC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       rota;
    logic       rotb;
    logic       rot_event;
    logic       rot_left;
    logic       rot_pulse;
    logic [7:0] step_count;

    rotary_shaft_decoder #(
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rota       (rota),
        .rotb       (rotb),
        .rot_event  (rot_event),
        .rot_left   (rot_left),
        .rot_pulse  (rot_pulse),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       left;
        logic [7:0] count;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] exp_count = 8'd0;
    logic       prev_pulse = 1'b0;
    logic       cnt_pending = 1'b0;
    logic [7:0] cnt_expected = 8'd0;

    // Scoreboard monitor: every rot_pulse pops one expected detent; the tally
    // is compared on the following cycle, when it has absorbed the pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_pulse  = 1'b0;
                cnt_pending = 1'b0;
            end else begin
                if (cnt_pending) begin
                    checks++;
                    if (step_count !== cnt_expected) begin
                        failures++;
                        $display("FAIL sb_step_count: got %h expected %h", step_count, cnt_expected);
                    end
                    cnt_pending = 1'b0;
                end
                if (rot_pulse === 1'b1) begin
                    checks++;
                    if (prev_pulse) begin
                        failures++;
                        $display("FAIL pulse_width: rot_pulse high 2 cycles, expected 1");
                    end else if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_pulse: got rot_pulse=1 expected none at %0t", $time);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (rot_left !== mon_e.left) begin
                            failures++;
                            $display("FAIL sb_rot_left: got %b expected %b", rot_left, mon_e.left);
                        end
                        cnt_pending  = 1'b1;
                        cnt_expected = mon_e.count;
                    end
                end
                prev_pulse = (rot_pulse === 1'b1);
            end
        end
    end

    task automatic apply(input logic [1:0] ab);
        rota = ab[1];
        rotb = ab[0];
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic left);
        exp_t e;
        exp_count = left ? exp_count - 8'd1 : exp_count + 8'd1;
        e.left  = left;
        e.count = exp_count;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        apply(2'b00);
        hold(3);
        reset = 1'b0;
        exp_q.delete();
        exp_count = 8'd0;
    endtask

    // Bounded wait for rot_event to go high; returns posedges elapsed.
    task automatic measure_rise(output int n);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (rot_event === 1'b1) break;
        end
    endtask

    task automatic check_drained(input string name);
        hold(LAT + 5);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_pulses: got %0d outstanding expected 0", name, exp_q.size());
        end
        checks++;
        if (step_count !== exp_count) begin
            failures++;
            $display("FAIL %s_step_count: got %h expected %h", name, step_count, exp_count);
        end
    endtask

    // One full quadrature cycle starting and ending at 00; q1 rises on 11.
    task automatic detent(input logic left, input int h);
        apply(left ? 2'b10 : 2'b01); hold(h);
        push_exp(left);
        apply(2'b11);                hold(h);
        apply(left ? 2'b01 : 2'b10); hold(h);
        apply(2'b00);                hold(h);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        apply(2'b11);
        hold(3);
        checks++;
        if ({rot_event, rot_left, rot_pulse, step_count} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b_%b_%b_%h expected all zero",
                     rot_event, rot_left, rot_pulse, step_count);
        end
        apply(2'b00);
        reset = 1'b0;
        hold(1);
        checks++;
        if ({rot_event, rot_left, rot_pulse, step_count} !== 11'd0) begin
            failures++;
            $display("FAIL reset_release: got %b_%b_%b_%h expected all zero",
                     rot_event, rot_left, rot_pulse, step_count);
        end
    endtask

    task automatic test_clockwise();
        int n;
        do_reset();
        apply(2'b01); hold(10);
        push_exp(1'b0);
        apply(2'b11);
        measure_rise(n);
        checks++;
        if (n != LAT) begin
            failures++;
            $display("FAIL cw_latency: got %0d cycles expected %0d", n, LAT);
        end
        hold(10);
        checks++;
        if (rot_left !== 1'b0) begin
            failures++;
            $display("FAIL cw_rot_left: got %b expected 0", rot_left);
        end
        apply(2'b10); hold(10);
        apply(2'b00); hold(10);
        check_drained("cw");
        checks++;
        if (step_count !== 8'd1) begin
            failures++;
            $display("FAIL cw_count: got %h expected 01", step_count);
        end
    endtask

    task automatic test_counter_clockwise();
        do_reset();
        detent(1'b1, 10);
        check_drained("ccw");
        checks++;
        if (step_count !== 8'hFF) begin
            failures++;
            $display("FAIL ccw_count: got %h expected ff", step_count);
        end
    endtask

    // Glitch on A from 00, then a direct jump to 11: rot_left exposes whether
    // the glitch reached q2.
    task automatic glitch_case(input string name, input int width, input logic expect_q2);
        logic quiet;
        do_reset();
        apply(2'b10); hold(width);
        apply(2'b00);
        quiet = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rot_event !== 1'b0 || rot_pulse !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin
            failures++;
            $display("FAIL %s_quiet: got output activity expected none", name);
        end
        push_exp(expect_q2);
        apply(2'b11); hold(12);
        apply(2'b00); hold(12);
        check_drained(name);
    endtask

    task automatic test_glitch();
        if (DBNC) glitch_case("glitch_short", D - 1, 1'b0);
        else      glitch_case("glitch_1cyc", 1, 1'b1);
        glitch_case("glitch_full", D, 1'b1);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 127; i++) detent(1'b0, 8);
        check_drained("wrap_127");
        checks++;
        if (step_count !== 8'd127) begin
            failures++;
            $display("FAIL wrap_preset: got %h expected 7f", step_count);
        end
        detent(1'b0, 8);
        check_drained("wrap_up");
        checks++;
        if (step_count !== 8'h80) begin
            failures++;
            $display("FAIL wrap_up_value: got %h expected 80", step_count);
        end
        detent(1'b1, 8);
        check_drained("wrap_down");
        checks++;
        if (step_count !== 8'h7F) begin
            failures++;
            $display("FAIL wrap_down_value: got %h expected 7f", step_count);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int n;
        do_reset();
        apply(2'b11);
        hold(DBNC ? 4 : 2);
        reset = 1'b1;
        hold(2);
        reset = 1'b0;
        exp_count = 8'd0;
        exp_q.delete();
        push_exp(1'b0);
        measure_rise(n);
        checks++;
        if (n != LAT) begin
            failures++;
            $display("FAIL rst_mid_latency: got %0d cycles expected %0d", n, LAT);
        end
        hold(10);
        check_drained("rst_mid");
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rota  = 1'b0;
        rotb  = 1'b0;
        test_reset();
        test_clockwise();
        test_counter_clockwise();
        test_glitch();
        test_wrap();
        test_reset_mid_debounce();
        hold(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
